// File: rtl/sram_allocator_if.sv
// Port-frontend / sram_state facing bundle of the SRAM allocation engine.
interface sram_allocator_if #(
  parameter int unsigned NUM_PORTS = 16,
  parameter int unsigned NUM_SRAMS = 32,
  parameter int unsigned PAGE_W    = 11
);
  localparam int unsigned PORT_W = $clog2(NUM_PORTS);
  localparam int unsigned SRAM_W = $clog2(NUM_SRAMS);

  logic [NUM_PORTS-1:0]             req_vld;
  logic [NUM_PORTS-1:0][PORT_W-1:0] req_dest;
  logic [NUM_PORTS-1:0][PAGE_W-1:0] req_pages;
  logic [NUM_PORTS-1:0]             release_lock;
  logic [NUM_SRAMS-1:0][PORT_W-1:0] probe_port;
  logic [NUM_SRAMS-1:0][PAGE_W-1:0] page_amount;
  logic [NUM_SRAMS-1:0][PAGE_W-1:0] free_space;
  logic [NUM_PORTS-1:0]             grant_vld;
  logic [NUM_PORTS-1:0]             grant_fail;
  logic [NUM_PORTS-1:0][SRAM_W-1:0] grant_sram;
  logic [NUM_SRAMS-1:0]             locked;

  modport master (
    output req_vld, req_dest, req_pages, release_lock, page_amount, free_space,
    input  probe_port, grant_vld, grant_fail, grant_sram, locked
  );

  modport slave (
    input  req_vld, req_dest, req_pages, release_lock, page_amount, free_space,
    output probe_port, grant_vld, grant_fail, grant_sram, locked
  );
endinterface

// File: rtl/sram_allocator.sv
// Per-port SRAM allocation engine: rotating collision-free sweep, best-fit pick, lock arbitration.
module sram_allocator #(
  parameter int unsigned NUM_PORTS = 16,
  parameter int unsigned NUM_SRAMS = 32,
  parameter int unsigned PAGE_W    = 11,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_allocator_if.slave bus
);
  localparam int unsigned PORT_W  = $clog2(NUM_PORTS);
  localparam int unsigned SRAM_W  = $clog2(NUM_SRAMS);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_EVAL, S_COMMIT, S_HOLD} state_t;

  state_t                            state_q [NUM_PORTS];
  state_t                            state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0][PORT_W-1:0]  dest_q, dest_d;
  logic [NUM_PORTS-1:0][PAGE_W-1:0]  pages_q, pages_d;
  logic [NUM_PORTS-1:0][SRAM_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [NUM_PORTS-1:0][RETRY_W-1:0] retry_q, retry_d;
  logic [NUM_PORTS-1:0]              best_vld_q, best_vld_d;
  logic [NUM_PORTS-1:0][SRAM_W-1:0]  best_q, best_d;
  logic [NUM_PORTS-1:0][PAGE_W-1:0]  best_amt_q, best_amt_d;
  logic [NUM_PORTS-1:0]              grant_vld_q, grant_vld_d;
  logic [NUM_PORTS-1:0]              grant_fail_q, grant_fail_d;
  logic [NUM_PORTS-1:0][SRAM_W-1:0]  grant_sram_q, grant_sram_d;
  logic [NUM_SRAMS-1:0]              locked_q, locked_d;
  logic [NUM_SRAMS-1:0][PORT_W-1:0]  probe_q, probe_d;
  logic [SRAM_W-1:0]                 phase_q;

  logic [NUM_PORTS-1:0]              eval_en, claim, win;
  logic [NUM_PORTS-1:0][SRAM_W-1:0]  eval_sram, next_sram;

  // Which SRAM each port's answer refers to, where it probes next cycle, and its commit claim.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      eval_en[p]   = (state_q[p] == S_SCAN && scan_cnt_q[p] != '0) || state_q[p] == S_EVAL;
      eval_sram[p] = phase_q + SRAM_W'(p) - SRAM_W'(1);
      next_sram[p] = phase_q + SRAM_W'(p) + SRAM_W'(1);
      claim[p]     = state_q[p] == S_COMMIT && best_vld_q[p] && !locked_q[best_q[p]] &&
                     bus.free_space[best_q[p]] >= pages_q[p];
    end
  end

  // Same-SRAM claims in one cycle: the lowest port index wins.
  always_comb begin
    win = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      win[p] = claim[p];
      for (int q = 0; q < p; q++) begin
        if (claim[q] && best_q[q] == best_q[p]) win[p] = 1'b0;
      end
    end
  end

  // Per-port next state, candidate tracking, lock table and registered probe bus.
  always_comb begin
    locked_d     = locked_q;
    probe_d      = '0;
    dest_d       = dest_q;
    pages_d      = pages_q;
    scan_cnt_d   = scan_cnt_q;
    retry_d      = retry_q;
    best_vld_d   = best_vld_q;
    best_d       = best_q;
    best_amt_d   = best_amt_q;
    grant_vld_d  = '0;
    grant_fail_d = '0;
    grant_sram_d = grant_sram_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];

      if (eval_en[p] && !locked_q[eval_sram[p]] &&
          bus.free_space[eval_sram[p]] >= pages_q[p] &&
          (!best_vld_q[p] || bus.page_amount[eval_sram[p]] > best_amt_q[p])) begin
        best_vld_d[p] = 1'b1;
        best_d[p]     = eval_sram[p];
        best_amt_d[p] = bus.page_amount[eval_sram[p]];
      end

      case (state_q[p])
        S_IDLE: begin
          if (bus.req_vld[p]) begin
            dest_d[p]     = bus.req_dest[p];
            pages_d[p]    = bus.req_pages[p];
            best_vld_d[p] = 1'b0;
            best_amt_d[p] = '0;
            retry_d[p]    = '0;
            scan_cnt_d[p] = '0;
            state_d[p]    = S_SCAN;
          end
        end
        S_SCAN: begin
          if (scan_cnt_q[p] == SRAM_W'(NUM_SRAMS - 1)) begin
            state_d[p] = S_EVAL;
          end else begin
            scan_cnt_d[p] = scan_cnt_q[p] + SRAM_W'(1);
          end
        end
        S_EVAL: state_d[p] = S_COMMIT;
        S_COMMIT: begin
          if (win[p]) begin
            locked_d[best_q[p]] = 1'b1;
            grant_sram_d[p]     = best_q[p];
            grant_vld_d[p]      = 1'b1;
            state_d[p]          = S_HOLD;
          end else if (retry_q[p] == RETRY_W'(MAX_RETRY)) begin
            grant_fail_d[p] = 1'b1;
            state_d[p]      = S_IDLE;
          end else begin
            best_vld_d[p] = 1'b0;
            best_amt_d[p] = '0;
            retry_d[p]    = retry_q[p] + RETRY_W'(1);
            scan_cnt_d[p] = '0;
            state_d[p]    = S_SCAN;
          end
        end
        S_HOLD: begin
          if (bus.release_lock[p]) begin
            locked_d[grant_sram_q[p]] = 1'b0;
            state_d[p]                = S_IDLE;
          end
        end
        default: state_d[p] = S_IDLE;
      endcase

      if (state_d[p] == S_SCAN) probe_d[next_sram[p]] = dest_d[p];
    end
  end

  // State registers; reset aborts every sweep and hold and drops all locks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= S_IDLE;
      dest_q       <= '0;
      pages_q      <= '0;
      scan_cnt_q   <= '0;
      retry_q      <= '0;
      best_vld_q   <= '0;
      best_q       <= '0;
      best_amt_q   <= '0;
      grant_vld_q  <= '0;
      grant_fail_q <= '0;
      grant_sram_q <= '0;
      locked_q     <= '0;
      probe_q      <= '0;
      phase_q      <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= state_d[p];
      dest_q       <= dest_d;
      pages_q      <= pages_d;
      scan_cnt_q   <= scan_cnt_d;
      retry_q      <= retry_d;
      best_vld_q   <= best_vld_d;
      best_q       <= best_d;
      best_amt_q   <= best_amt_d;
      grant_vld_q  <= grant_vld_d;
      grant_fail_q <= grant_fail_d;
      grant_sram_q <= grant_sram_d;
      locked_q     <= locked_d;
      probe_q      <= probe_d;
      phase_q      <= phase_q + SRAM_W'(1);
    end
  end

  assign bus.grant_vld  = grant_vld_q;
  assign bus.grant_fail = grant_fail_q;
  assign bus.grant_sram = grant_sram_q;
  assign bus.locked     = locked_q;
  assign bus.probe_port = probe_q;
endmodule

// File: tb/tb_sram_allocator.sv
// Bench for sram_allocator: directed scenarios plus random requests against a round-level model.
module tb_sram_allocator;
  localparam int unsigned NP     = 4;
  localparam int unsigned NS     = 8;
  localparam int unsigned PW     = 11;
  localparam int unsigned MR     = 1;
  localparam int unsigned BUDGET = 26;

  logic        clk;
  logic        rst_n;
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc;

  logic [PW-1:0] amt_tbl   [NS][NP];
  logic [PW-1:0] free_tbl  [NS];
  logic [1:0]    dest_tbl  [NP];
  logic [PW-1:0] pages_tbl [NP];
  logic [NS-1:0] mdl_lock;
  bit            held_vld  [NP];
  int            held_sram [NP];
  int            exp_kind [NP], exp_sram [NP], exp_off [NP];
  int            obs_kind [NP], obs_sram [NP], obs_off [NP];

  sram_allocator_if #(.NUM_PORTS(NP), .NUM_SRAMS(NS), .PAGE_W(PW)) bus ();

  sram_allocator #(.NUM_PORTS(NP), .NUM_SRAMS(NS), .PAGE_W(PW), .MAX_RETRY(MR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycles since reset release; equals the allocator's rotation phase modulo NS.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // sram_state stand-in: answers each probe one cycle later.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) bus.page_amount[s] <= amt_tbl[s][bus.probe_port[s]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_tables();
    for (int s = 0; s < NS; s++) bus.free_space[s] = free_tbl[s];
    for (int p = 0; p < NP; p++) begin
      bus.req_dest[p]  = dest_tbl[p];
      bus.req_pages[p] = pages_tbl[p];
    end
  endtask

  // Round-by-round outcome of simultaneous requests issued in a cycle with phase ph.
  task automatic model(input logic [NP-1:0] mask, input int unsigned ph);
    logic [NP-1:0] act;
    bit            taken [NS];
    int            best  [NP];
    act = mask;
    for (int p = 0; p < NP; p++) exp_kind[p] = 0;
    for (int r = 0; r <= int'(MR); r++) begin
      int unsigned start;
      start = ph + 1 + r * (NS + 2);
      for (int p = 0; p < NP; p++) begin
        best[p] = -1;
        if (act[p]) begin
          for (int k = 0; k < int'(NS); k++) begin
            int s;
            s = int'((start + p + k) % NS);
            if (!mdl_lock[s] && free_tbl[s] >= pages_tbl[p]) begin
              if (best[p] < 0 || amt_tbl[s][dest_tbl[p]] > amt_tbl[best[p]][dest_tbl[p]]) best[p] = s;
            end
          end
        end
      end
      for (int s = 0; s < NS; s++) taken[s] = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (act[p]) begin
          if (best[p] >= 0 && !taken[best[p]]) begin
            taken[best[p]]   = 1'b1;
            mdl_lock[best[p]] = 1'b1;
            exp_kind[p]  = 1;
            exp_sram[p]  = best[p];
            exp_off[p]   = NS + 3 + r * (NS + 2);
            held_vld[p]  = 1'b1;
            held_sram[p] = best[p];
            act[p]       = 1'b0;
          end else if (r == int'(MR)) begin
            exp_kind[p] = 2;
            exp_off[p]  = NS + 3 + r * (NS + 2);
            act[p]      = 1'b0;
          end
        end
      end
    end
  endtask

  // Issue a request from the ports in mask (called right after a negedge) and check the outcome.
  task automatic issue(input logic [NP-1:0] mask);
    int unsigned          ph;
    logic [NS-1:0][1:0]   exp_probe;
    apply_tables();
    ph = cyc % NS;
    model(mask, ph);
    for (int p = 0; p < NP; p++) begin
      obs_kind[p] = 0;
      obs_sram[p] = 0;
      obs_off[p]  = 0;
    end
    bus.req_vld = mask;
    for (int k = 1; k <= int'(BUDGET); k++) begin
      @(negedge clk);
      bus.req_vld = '0;
      if (k <= int'(NS)) begin
        exp_probe = '0;
        for (int p = 0; p < NP; p++) if (mask[p]) exp_probe[(ph + k + p) % NS] = dest_tbl[p];
        check($sformatf("probe_port@%0d", k), 32'(bus.probe_port), 32'(exp_probe));
      end
      for (int p = 0; p < NP; p++) begin
        if (obs_kind[p] == 0) begin
          if (bus.grant_vld[p]) begin
            obs_kind[p] = 1;
            obs_sram[p] = int'(bus.grant_sram[p]);
            obs_off[p]  = k;
            check($sformatf("lock_at_grant[%0d]", p), 32'(bus.locked[bus.grant_sram[p]]), 32'd1);
          end else if (bus.grant_fail[p]) begin
            obs_kind[p] = 2;
            obs_off[p]  = k;
          end
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      check($sformatf("outcome[%0d]", p), obs_kind[p], exp_kind[p]);
      if (exp_kind[p] != 0) check($sformatf("latency[%0d]", p), obs_off[p], exp_off[p]);
      if (exp_kind[p] == 1) check($sformatf("grant_sram[%0d]", p), obs_sram[p], exp_sram[p]);
    end
    check("locked_after_req", 32'(bus.locked), 32'(mdl_lock));
  endtask

  task automatic release_ports(input logic [NP-1:0] mask);
    bus.release_lock = mask;
    @(negedge clk);
    bus.release_lock = '0;
    for (int p = 0; p < NP; p++) begin
      if (mask[p] && held_vld[p]) begin
        mdl_lock[held_sram[p]] = 1'b0;
        held_vld[p] = 1'b0;
      end
    end
    check("locked_after_release", 32'(bus.locked), 32'(mdl_lock));
  endtask

  task automatic align(input int unsigned t);
    while (cyc % NS != t) @(negedge clk);
  endtask

  task automatic clear_tables();
    for (int s = 0; s < NS; s++) begin
      free_tbl[s] = 11'd100;
      for (int d = 0; d < NP; d++) amt_tbl[s][d] = '0;
    end
    for (int p = 0; p < NP; p++) begin
      dest_tbl[p]  = 2'd0;
      pages_tbl[p] = 11'd4;
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    bus.req_vld = '0;
    bus.release_lock = '0;
    mdl_lock = '0;
    for (int p = 0; p < NP; p++) held_vld[p] = 1'b0;
    clear_tables();
    apply_tables();
    repeat (2) @(negedge clk);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_grant_vld", 32'(bus.grant_vld), 32'd0);
    check("rst_grant_sram", 32'(bus.grant_sram), 32'd0);
    check("rst_probe", 32'(bus.probe_port), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: ties between SRAM1 and SRAM3 go to the earlier-visited one.
    amt_tbl[1][2] = 11'd5;
    amt_tbl[2][2] = 11'd3;
    amt_tbl[3][2] = 11'd5;
    dest_tbl[0] = 2'd2;
    align(7);
    issue(4'b0001);
    check("t1_sram", obs_sram[0], 1);
    check("t1_latency", obs_off[0], 11);
    check("t1_locked", 32'(bus.locked), 32'h02);
    release_ports(4'b0001);

    // Space filter, then no SRAM fits at all.
    free_tbl[1] = 11'd3;
    align(7);
    issue(4'b0001);
    check("t2_sram", obs_sram[0], 3);
    release_ports(4'b0001);
    for (int s = 0; s < NS; s++) free_tbl[s] = 11'd3;
    issue(4'b0001);
    check("t2_fail", obs_kind[0], 2);
    check("t2_fail_latency", obs_off[0], 21);
    check("t2_locked", 32'(bus.locked), 32'd0);

    // Contention on a unique best SRAM 5.
    clear_tables();
    for (int s = 0; s < NS; s++) amt_tbl[s][1] = 11'(s + 1);
    amt_tbl[4][1] = 11'd0;
    amt_tbl[5][1] = 11'd9;
    amt_tbl[6][1] = 11'd5;
    amt_tbl[7][1] = 11'd6;
    dest_tbl[0] = 2'd1;
    dest_tbl[2] = 2'd1;
    align(7);
    issue(4'b0101);
    check("t3_p0_sram", obs_sram[0], 5);
    check("t3_p0_latency", obs_off[0], 11);
    check("t3_p2_sram", obs_sram[2], 7);
    check("t3_p2_latency", obs_off[2], 21);
    release_ports(4'b0101);

    // Lock exclusion: port 3 holds SRAM1, port 0 must go elsewhere until released.
    clear_tables();
    amt_tbl[1][2] = 11'd5;
    amt_tbl[2][2] = 11'd3;
    amt_tbl[3][2] = 11'd5;
    dest_tbl[0] = 2'd2;
    dest_tbl[3] = 2'd2;
    align(5);
    issue(4'b1000);
    check("t4_p3_sram", obs_sram[3], 1);
    issue(4'b0001);
    check("t4_p0_not1", 32'(obs_sram[0] == 1), 32'd0);
    release_ports(4'b1000);
    check("t4_unlock1", 32'(bus.locked[1]), 32'd0);
    release_ports(4'b0001);
    align(7);
    issue(4'b0001);
    check("t4_p0_gets1", obs_sram[0], 1);
    release_ports(4'b0001);

    // Random trials; the first keeps all four ports scanning with nonzero dests.
    for (int t = 0; t < 8; t++) begin
      logic [NP-1:0] mask;
      mask = (t == 0) ? 4'hF : 4'($urandom_range(1, 15));
      for (int p = 0; p < NP; p++) begin
        dest_tbl[p]  = (t == 0) ? 2'(1 + p % 3) : 2'($urandom_range(0, 3));
        pages_tbl[p] = 11'($urandom_range(1, 24));
      end
      for (int s = 0; s < NS; s++) begin
        free_tbl[s] = 11'($urandom_range(0, 40));
        for (int d = 0; d < NP; d++) amt_tbl[s][d] = 11'($urandom_range(0, 15));
      end
      repeat ($urandom_range(0, 7)) @(negedge clk);
      issue(mask);
      release_ports(4'hF);
    end

    // Async reset while port 1 holds a lock and port 0 is mid-sweep.
    clear_tables();
    dest_tbl[1] = 2'd2;
    issue(4'b0010);
    bus.req_vld = 4'b0001;
    @(negedge clk);
    bus.req_vld = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_locked", 32'(bus.locked), 32'd0);
    check("rst_mid_grant_vld", 32'(bus.grant_vld), 32'd0);
    check("rst_mid_grant_fail", 32'(bus.grant_fail), 32'd0);
    check("rst_mid_grant_sram", 32'(bus.grant_sram), 32'd0);
    check("rst_mid_probe", 32'(bus.probe_port), 32'd0);
    mdl_lock = '0;
    for (int p = 0; p < NP; p++) held_vld[p] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (|bus.grant_vld || |bus.grant_fail) pulses++;
    end
    check("no_pulse_after_reset", pulses, 0);
    dest_tbl[0] = 2'd3;
    issue(4'b0001);
    check("post_rst_latency", obs_off[0], 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
